// File: rtl/tx_shift_loader_if.sv
// ---------------------------------------------------------------------------
// tx_shift_loader_if
//
// Bundles the host write/commit port, the consumer strobe port and the
// status/sample outputs of tx_shift_loader.
//
//   wr_en, wr_addr, wr_data : staging-bank write port (host -> block)
//   commit                  : one-cycle pulse marking staging as a full frame
//   txstrobe                : consumer takes tx_sample this cycle
//   clear_flags             : clears underrun / overflow
//   tx_sample               : current head sample, 0 when idle
//   tx_valid                : a frame is being shifted out
//   pending                 : committed frame waiting, staging locked
//   underrun, overflow      : sticky error flags
//
// Modports: master = host/consumer side, slave = tx_shift_loader.
// ---------------------------------------------------------------------------
interface tx_shift_loader_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              commit;
    logic              txstrobe;
    logic              clear_flags;
    logic [WIDTH-1:0]  tx_sample;
    logic              tx_valid;
    logic              pending;
    logic              underrun;
    logic              overflow;

    modport master (
        output wr_en, wr_addr, wr_data, commit, txstrobe, clear_flags,
        input  tx_sample, tx_valid, pending, underrun, overflow
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, txstrobe, clear_flags,
        output tx_sample, tx_valid, pending, underrun, overflow
    );
endinterface

// File: rtl/tx_shift_loader.sv
// ---------------------------------------------------------------------------
// tx_shift_loader
//
// Double-buffered transmit frame loader. The host fills a DEPTH-entry staging
// bank by index and commits it; the frame is then copied into an output
// shifter and presented one sample per txstrobe, index 0 first. While a frame
// drains, the next one can be written and committed; if it is committed
// before the last sample is taken, it is loaded on the same edge that
// consumes the last sample, so frames stream without a gap.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : tx_shift_loader_if.slave (write port, commit, strobe, status)
// ---------------------------------------------------------------------------
module tx_shift_loader #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    tx_shift_loader_if.slave   bus
);
    localparam logic [2:0] LAST_IDX = 3'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] count_reg, count_next;
    logic       pending_reg, pending_next;
    logic       underrun_reg, underrun_next;
    logic       overflow_reg, overflow_next;

    // load: shifter takes the whole staging bank; advance: shifter moves one
    // entry toward the head, pulling zeros in at the tail.
    logic       load;
    logic       advance;
    logic       wr_accept;
    logic       commit_accept;

    logic [WIDTH-1:0] stage_word [DEPTH];
    logic [WIDTH-1:0] shift_word [DEPTH];
    logic [WIDTH-1:0] shift_in   [DEPTH];

    // Staging is locked while a committed frame waits for the shifter.
    assign wr_accept     = bus.wr_en && !pending_reg && (bus.wr_addr < 3'(DEPTH));
    assign commit_accept = bus.commit && !pending_reg;

    // -----------------------------------------------------------------------
    // Next-state / control
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        load       = 1'b0;
        advance    = 1'b0;

        if (state_reg == IDLE) begin
            if (pending_reg) begin
                load       = 1'b1;
                count_next = '0;
                state_next = RUN;
            end
        end else begin
            if (bus.txstrobe) begin
                if (count_reg == LAST_IDX) begin
                    count_next = '0;
                    if (pending_reg) begin
                        // Seamless reload on the edge that consumes the last sample.
                        load = 1'b1;
                    end else begin
                        // Shifting once more leaves only zeros in the head.
                        advance    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    advance    = 1'b1;
                    count_next = count_reg + 3'd1;
                end
            end
        end
    end

    always_comb begin
        pending_next  = pending_reg;
        underrun_next = underrun_reg;
        overflow_next = overflow_reg;

        // load only ever happens with pending_reg=1 and a commit is only
        // accepted with pending_reg=0, so the two never collide.
        if (load) begin
            pending_next = 1'b0;
        end else if (commit_accept) begin
            pending_next = 1'b1;
        end

        // Clear first so a same-cycle set condition wins.
        if (bus.clear_flags) begin
            underrun_next = 1'b0;
            overflow_next = 1'b0;
        end
        if (state_reg == IDLE && bus.txstrobe) begin
            underrun_next = 1'b1;
        end
        if (pending_reg && (bus.commit || bus.wr_en)) begin
            overflow_next = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            pending_reg  <= 1'b0;
            underrun_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            pending_reg  <= pending_next;
            underrun_reg <= underrun_next;
            overflow_reg <= overflow_next;
        end
    end

    // -----------------------------------------------------------------------
    // Staging bank and output shifter, one slice per entry
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] stage_reg;
            logic [WIDTH-1:0] shift_reg;

            if (gi == DEPTH - 1) begin : g_tail
                assign shift_in[gi] = '0;
            end else begin : g_body
                assign shift_in[gi] = shift_word[gi + 1];
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    stage_reg <= '0;
                    shift_reg <= '0;
                end else begin
                    if (wr_accept && bus.wr_addr == 3'(gi)) begin
                        stage_reg <= bus.wr_data;
                    end
                    if (load) begin
                        shift_reg <= stage_reg;
                    end else if (advance) begin
                        shift_reg <= shift_in[gi];
                    end
                end
            end

            assign stage_word[gi] = stage_reg;
            assign shift_word[gi] = shift_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs (all straight from flops)
    // -----------------------------------------------------------------------
    assign bus.tx_sample = shift_word[0];
    assign bus.tx_valid  = (state_reg == RUN);
    assign bus.pending   = pending_reg;
    assign bus.underrun  = underrun_reg;
    assign bus.overflow  = overflow_reg;

endmodule
